// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external 16-bit combinational ALU between two requesters
// (port 0: instruction datapath, port 1: address/auxiliary unit). One
// operation is in flight at a time. The winner's operands and operation code
// are latched into the ALU input registers on the accept edge. The ALU
// result and zero flag are captured at the end of EXEC. They are then handed
// back to the owner with a one-cycle done pulse.
//
// Handshake: reqX is a level. It is sampled only on a clock edge where the
// block can accept (IDLE or DONE state). gntX is high combinationally
// during the cycle whose closing edge latches aX/bX/ctrlX. A requester that
// keeps reqX high after its gnt issues a further operation. doneX is high
// for exactly one cycle, and in that cycle result/zero belong to port X.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req0/req1                 request valid per requester
//   a0,b0,ctrl0 / a1,b1,ctrl1 operands and ALU op code per requester
//   gnt0/gnt1                 acceptance pulse (combinational)
//   done0/done1               completion pulse (registered)
//   result, zero              registered ALU result / zero flag
//   busy                      high while in EXEC
//   Alu_inputA/B, Alu_control registered ALU inputs
//   Alu_result, Alu_zero      ALU outputs
//   dbg_state                 current FSM state (0=IDLE, 1=EXEC, 2=DONE)
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [WIDTH-1:0]  a0,
    input  logic [WIDTH-1:0]  b0,
    input  logic [WIDTH-1:0]  a1,
    input  logic [WIDTH-1:0]  b1,
    input  logic [CTRL_W-1:0] ctrl0,
    input  logic [CTRL_W-1:0] ctrl1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              busy,
    output logic [WIDTH-1:0]  Alu_inputA,
    output logic [WIDTH-1:0]  Alu_inputB,
    output logic [CTRL_W-1:0] Alu_control,
    input  logic [WIDTH-1:0]  Alu_result,
    input  logic              Alu_zero,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   owner;     // port that owns the in-flight operation
    logic   last_gnt;  // port granted most recently; resets to 1 so port 0 wins first tie
    logic   accept;
    logic   winner;

    // Gating with rst keeps gnt low while reset is asserted. The state
    // register is already IDLE then, so an accept would otherwise be
    // signalled for an edge that cannot latch anything.
    always_comb begin
        accept = 1'b0;
        winner = 1'b0;
        if (!rst && (state == IDLE || state == DONE) && (req0 || req1)) begin
            accept = 1'b1;
        end
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else begin
            winner = req1;
        end
    end

    assign gnt0      = accept && !winner;
    assign gnt1      = accept &&  winner;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_gnt    <= 1'b1;
            done0       <= 1'b0;
            done1       <= 1'b0;
            busy        <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            Alu_inputA  <= '0;
            Alu_inputB  <= '0;
            Alu_control <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        Alu_inputA  <= winner ? a1 : a0;
                        Alu_inputB  <= winner ? b1 : b0;
                        Alu_control <= winner ? ctrl1 : ctrl0;
                        owner       <= winner;
                        last_gnt    <= winner;
                        busy        <= 1'b1;
                        state       <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    // The ALU has had the whole cycle to settle on the
                    // registered inputs.
                    result <= Alu_result;
                    zero   <= Alu_zero;
                    done0  <= !owner;
                    done1  <= owner;
                    state  <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter with a behavioural ALU attached. Each grant
// the bench expects pushes {due cycle, port, zero, result} into exp_q. The
// values come from the bench's own operand variables. Each cycle, the head
// of the queue is compared against done/result/zero once its due cycle is
// reached.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int W  = 16;
    localparam int CW = 3;
    localparam int EW = 34; // {due[15:0], port, zero, result[15:0]}

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req0, req1;
    logic [W-1:0]  a0, b0, a1, b1;
    logic [CW-1:0] ctrl0, ctrl1;
    logic          gnt0, gnt1, done0, done1, zero, busy;
    logic [W-1:0]  result, alu_a, alu_b, alu_r;
    logic [CW-1:0] alu_c;
    logic          alu_z;
    logic [1:0]    dbg_state;

    alu_arbiter #(.WIDTH(W), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ctrl0(ctrl0), .ctrl1(ctrl1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .result(result), .zero(zero), .busy(busy),
        .Alu_inputA(alu_a), .Alu_inputB(alu_b), .Alu_control(alu_c),
        .Alu_result(alu_r), .Alu_zero(alu_z),
        .dbg_state(dbg_state)
    );

    // Behavioural ALU; returns {zero, result}.
    function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [CW-1:0] c);
        logic [W-1:0] r;
        case (c)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = ~(a | b);
            3'd5:    r = a ^ b;
            3'd6:    r = a << b[3:0];
            default: r = a >> b[3:0];
        endcase
        return {(r == '0), r};
    endfunction

    assign {alu_z, alu_r} = alu_f(alu_a, alu_b, alu_c);

    // scoreboard
    logic [EW-1:0] exp_q[$];
    logic [15:0]   cyc;
    int            checks;
    int            failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"},  gnt0,   0);
        chk({tag, "_gnt1"},  gnt1,   0);
        chk({tag, "_done0"}, done0,  0);
        chk({tag, "_done1"}, done1,  0);
        chk({tag, "_busy"},  busy,   0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_zero"},  zero,   0);
        chk({tag, "_alu_a"}, alu_a,  0);
        chk({tag, "_alu_b"}, alu_b,  0);
        chk({tag, "_alu_c"}, alu_c,  0);
    endtask

    // One clock cycle: check at the falling edge, then advance to 1 time
    // unit after the next rising edge, where the caller drives new inputs.
    task automatic run(input logic eg0, input logic eg1);
        logic [EW-1:0] h;
        logic [W:0]    m;
        logic          exp_busy;
        @(negedge clk);
        chk("gnt0", gnt0, eg0);
        chk("gnt1", gnt1, eg1);
        exp_busy = (exp_q.size() > 0) && (exp_q[0][33:18] == cyc + 16'd1);
        chk("busy", busy, exp_busy);
        if (exp_q.size() > 0 && exp_q[0][33:18] == cyc) begin
            h = exp_q.pop_front();
            chk("done0",  done0,  !h[17]);
            chk("done1",  done1,  h[17]);
            chk("result", result, h[15:0]);
            chk("zero",   zero,   h[16]);
        end else begin
            chk("idle_done0", done0, 0);
            chk("idle_done1", done1, 0);
        end
        if (eg0) begin
            m = alu_f(a0, b0, ctrl0);
            exp_q.push_back({cyc + 16'd2, 1'b0, m});
        end
        if (eg1) begin
            m = alu_f(a1, b1, ctrl1);
            exp_q.push_back({cyc + 16'd2, 1'b1, m});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1;
        req0 = 0; req1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; ctrl0 = '0; ctrl1 = '0;

        // reset state
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // single op: port 0 sub 5-3
        req0 = 1; a0 = 16'h0005; b0 = 16'h0003; ctrl0 = 3'd1;
        run(1, 0);
        req0 = 0;
        run(0, 0);
        run(0, 0);
        run(0, 0);

        // zero flag: port 1 xor equal operands
        req1 = 1; a1 = 16'h1234; b1 = 16'h1234; ctrl1 = 3'd5;
        run(0, 1);
        req1 = 0;
        run(0, 0);
        run(0, 0);
        run(0, 0);

        // contention: both held, grants alternate starting with port 0
        req0 = 1; a0 = 16'hFFFF; b0 = 16'h0001; ctrl0 = 3'd0;
        req1 = 1; a1 = 16'h0001; b1 = 16'h0004; ctrl1 = 3'd6;
        run(1, 0);
        run(0, 0);
        run(0, 1);
        run(0, 0);
        a0 = 16'h00F0; b0 = 16'h0F00; ctrl0 = 3'd4; // nor on the next port-0 op
        run(1, 0);
        run(0, 0);
        run(0, 1);
        req0 = 0; req1 = 0;
        run(0, 0);
        run(0, 0);
        run(0, 0);

        // back-to-back on port 0
        req0 = 1; a0 = 16'h0002; b0 = 16'h0003; ctrl0 = 3'd0;
        run(1, 0);
        a0 = 16'h00F0; b0 = 16'h000F; ctrl0 = 3'd3;
        run(0, 0);
        run(1, 0);
        req0 = 0;
        run(0, 0);
        run(0, 0);
        run(0, 0);

        // reset during EXEC: everything clears, no done follows
        req0 = 1; a0 = 16'h0007; b0 = 16'h0001; ctrl0 = 3'd7;
        run(1, 0);
        req0 = 0;
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_reset");
        exp_q.delete();
        @(posedge clk); #1;
        cyc++;
        rst = 1'b0;
        run(0, 0);
        run(0, 0);

        // pointer back to 1: port 0 wins the first tie after reset
        req0 = 1; a0 = 16'h00AA; b0 = 16'h0055; ctrl0 = 3'd2;
        req1 = 1; a1 = 16'h0010; b1 = 16'h0001; ctrl1 = 3'd1;
        run(1, 0);
        req0 = 0; req1 = 0;
        run(0, 0);
        run(0, 0);
        run(0, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
